zxuno_regbus_decoder: RTL and testbench

//  Front end of the ZXUNO register file. Decodes Z80 I/O cycles to the address

---
 rtl/zxuno_regbus_decoder.sv | 122 ++++++++++++
 tb/tb_zxuno_regbus_decoder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/zxuno_regbus_decoder.sv
// Decodes Z80 I/O cycles to the ZXUNO register-number and register-data ports,
// filters the strobes and produces single-cycle read/write pulses for register blocks.
module zxuno_regbus_decoder #(
    parameter logic [15:0] ADDR_PORT = 16'hFC3B,
    parameter logic [15:0] DATA_PORT = 16'hFD3B,
    parameter int          FILTER    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_a,
    input  logic        cpu_iorq_n,
    input  logic        cpu_rd_n,
    input  logic        cpu_wr_n,
    input  logic        cpu_m1_n,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic        cpu_oe,
    output logic [7:0]  zxuno_addr,
    output logic [7:0]  zxuno_wdata,
    output logic        zxuno_regwr,
    output logic        zxuno_regrd,
    input  logic [7:0]  zxuno_rdata,
    input  logic        zxuno_roe
);

    localparam int CW = $clog2(FILTER + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(FILTER);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER - 1);

    logic       wr_s;
    logic       rd_s;
    logic [1:0] strobe;
    logic [1:0] hit;
    logic       wr_acc;
    logic       rd_acc;
    logic       addr_hit;
    logic       data_hit;

    logic [7:0] cpu_dout_reg;
    logic       cpu_oe_reg;
    logic [7:0] zxuno_addr_reg;
    logic [7:0] zxuno_wdata_reg;
    logic       zxuno_regwr_reg;
    logic       zxuno_regrd_reg;

    assign wr_s   = ~cpu_iorq_n & ~cpu_wr_n & cpu_m1_n;
    assign rd_s   = ~cpu_iorq_n & ~cpu_rd_n & cpu_m1_n;
    assign strobe = {rd_s, wr_s};

    // Per-strobe glitch filter. The armed flag is cleared by reset so a strobe
    // already active at reset release must go inactive before it can fire.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_filter
            logic [CW-1:0] cnt_reg;
            logic          armed_reg;

            assign hit[gi] = strobe[gi] & armed_reg & (cnt_reg == CNT_LAST);

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg   <= '0;
                    armed_reg <= 1'b0;
                end else if (!strobe[gi]) begin
                    cnt_reg   <= '0;
                    armed_reg <= 1'b1;
                end else begin
                    if (cnt_reg != CNT_MAX) begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                    if (hit[gi]) begin
                        armed_reg <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    // A simultaneous read is dropped in favour of the write.
    assign wr_acc   = hit[0];
    assign rd_acc   = hit[1] & ~hit[0];
    assign addr_hit = (cpu_a == ADDR_PORT);
    assign data_hit = (cpu_a == DATA_PORT);

    always_ff @(posedge clk) begin
        if (rst) begin
            zxuno_addr_reg  <= 8'h00;
            zxuno_wdata_reg <= 8'h00;
            zxuno_regwr_reg <= 1'b0;
            zxuno_regrd_reg <= 1'b0;
            cpu_oe_reg      <= 1'b0;
            cpu_dout_reg    <= 8'hFF;
        end else begin
            zxuno_regwr_reg <= wr_acc & data_hit;
            zxuno_regrd_reg <= rd_acc & data_hit;
            if (wr_acc && addr_hit) begin
                zxuno_addr_reg <= cpu_din;
            end
            if (wr_acc && data_hit) begin
                zxuno_wdata_reg <= cpu_din;
            end
            // End of the read cycle wins over any late data capture.
            if (!rd_s) begin
                cpu_oe_reg   <= 1'b0;
                cpu_dout_reg <= 8'hFF;
            end else if (rd_acc && addr_hit) begin
                cpu_oe_reg   <= 1'b1;
                cpu_dout_reg <= zxuno_addr_reg;
            end else if (zxuno_regrd_reg) begin
                cpu_oe_reg   <= 1'b1;
                cpu_dout_reg <= zxuno_roe ? zxuno_rdata : 8'hFF;
            end
        end
    end

    assign cpu_dout    = cpu_dout_reg;
    assign cpu_oe      = cpu_oe_reg;
    assign zxuno_addr  = zxuno_addr_reg;
    assign zxuno_wdata = zxuno_wdata_reg;
    assign zxuno_regwr = zxuno_regwr_reg;
    assign zxuno_regrd = zxuno_regrd_reg;

endmodule

// File: tb/tb_zxuno_regbus_decoder.sv
// Scoreboard bench for zxuno_regbus_decoder: accesses are modelled as whole bus
// transactions, expected pulses and read data are queued and popped by a monitor.
module tb_zxuno_regbus_decoder;

    localparam int          FILTER = 2;
    localparam logic [15:0] AP     = 16'hFC3B;
    localparam logic [15:0] DP     = 16'hFD3B;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_a;
    logic        cpu_iorq_n;
    logic        cpu_rd_n;
    logic        cpu_wr_n;
    logic        cpu_m1_n;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        cpu_oe;
    logic [7:0]  zxuno_addr;
    logic [7:0]  zxuno_wdata;
    logic        zxuno_regwr;
    logic        zxuno_regrd;
    logic [7:0]  zxuno_rdata;
    logic        zxuno_roe;

    always #5 clk = ~clk;

    zxuno_regbus_decoder #(
        .ADDR_PORT (AP),
        .DATA_PORT (DP),
        .FILTER    (FILTER)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_a       (cpu_a),
        .cpu_iorq_n  (cpu_iorq_n),
        .cpu_rd_n    (cpu_rd_n),
        .cpu_wr_n    (cpu_wr_n),
        .cpu_m1_n    (cpu_m1_n),
        .cpu_din     (cpu_din),
        .cpu_dout    (cpu_dout),
        .cpu_oe      (cpu_oe),
        .zxuno_addr  (zxuno_addr),
        .zxuno_wdata (zxuno_wdata),
        .zxuno_regwr (zxuno_regwr),
        .zxuno_regrd (zxuno_regrd),
        .zxuno_rdata (zxuno_rdata),
        .zxuno_roe   (zxuno_roe)
    );

    // Register-block stand-in: claims registers 00-7F, data = number ^ 32h, only during regrd.
    assign zxuno_roe   = zxuno_regrd & ~zxuno_addr[7];
    assign zxuno_rdata = zxuno_regrd ? (zxuno_addr ^ 8'h32) : 8'h00;

    // kind 0: write pulse (a=reg, d=wdata); 1: read pulse (a=reg); 2: cpu_oe rise (d=dout)
    typedef struct {
        int         kind;
        logic [7:0] a;
        logic [7:0] d;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    int         exp_pulses = 0;
    int         seen_pulses = 0;
    logic [7:0] model_addr = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic push(input int kind, input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        e.kind = kind;
        e.a    = a;
        e.d    = d;
        q.push_back(e);
    endtask

    task automatic idle_bus();
        cpu_iorq_n = 1'b1;
        cpu_rd_n   = 1'b1;
        cpu_wr_n   = 1'b1;
        cpu_m1_n   = 1'b1;
    endtask

    // One bus access; the model decides the outcome from the access as a whole.
    task automatic access(input bit is_wr, input logic [15:0] a, input logic [7:0] d,
                          input int len, input logic m1_n, input int gap);
        logic [7:0] rd_val;
        $display("access %s a=%h d=%h len=%0d m1_n=%0d", is_wr ? "WR" : "RD", a, d, len, m1_n);
        cpu_a      = a;
        cpu_din    = d;
        cpu_iorq_n = 1'b0;
        cpu_m1_n   = m1_n;
        if (is_wr) cpu_wr_n = 1'b0;
        else       cpu_rd_n = 1'b0;
        if (len >= FILTER && m1_n) begin
            if (is_wr) begin
                if (a == AP) model_addr = d;
                else if (a == DP) begin
                    push(0, model_addr, d);
                    exp_pulses++;
                end
            end else if (a == AP) begin
                push(2, 8'h00, model_addr);
            end else if (a == DP) begin
                push(1, model_addr, 8'h00);
                exp_pulses++;
                rd_val = (model_addr < 8'h80) ? (model_addr ^ 8'h32) : 8'hFF;
                if (len > FILTER) push(2, 8'h00, rd_val);
            end
        end
        repeat (len) @(posedge clk);
        #2;
        idle_bus();
        @(posedge clk);
        #2;
        if (!is_wr) begin
            chk("oe_release", cpu_oe, 1'b0);
            chk("dout_release", cpu_dout, 8'hFF);
        end
        repeat (gap) @(posedge clk);
        #2;
    endtask

    logic prev_pulse = 1'b0;
    logic prev_oe    = 1'b0;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (zxuno_regwr || zxuno_regrd) begin
                chk("pulse_exclusive", {zxuno_regwr & zxuno_regrd, prev_pulse}, 2'b00);
                seen_pulses++;
            end
            if (zxuno_regwr || zxuno_regrd || (cpu_oe && !prev_oe)) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got regwr=%0d regrd=%0d oe=%0d, expected nothing",
                             zxuno_regwr, zxuno_regrd, cpu_oe);
                end else begin
                    e = q.pop_front();
                    if (zxuno_regwr) begin
                        chk("wr_kind", 0, e.kind);
                        chk("wr_addr", zxuno_addr, e.a);
                        chk("wr_data", zxuno_wdata, e.d);
                    end else if (zxuno_regrd) begin
                        chk("rd_kind", 1, e.kind);
                        chk("rd_addr", zxuno_addr, e.a);
                    end else begin
                        chk("oe_kind", 2, e.kind);
                        chk("rd_dout", cpu_dout, e.d);
                    end
                end
            end
        end
        prev_pulse = zxuno_regwr | zxuno_regrd;
        prev_oe    = cpu_oe;
    end

    initial begin
        logic [15:0] ra;
        int          r;
        rst     = 1'b1;
        cpu_a   = 16'h0000;
        cpu_din = 8'h00;
        idle_bus();
        repeat (3) @(posedge clk);
        #2;
        chk("rst_addr", zxuno_addr, 8'h00);
        chk("rst_wdata", zxuno_wdata, 8'h00);
        chk("rst_pulses", {zxuno_regwr, zxuno_regrd}, 2'b00);
        chk("rst_oe", cpu_oe, 1'b0);
        chk("rst_dout", cpu_dout, 8'hFF);
        rst = 1'b0;
        @(posedge clk);
        #2;

        // Basic register write, read with claimed and unclaimed registers, address readback
        access(1'b1, AP, 8'h0E, 4, 1'b1, 1);
        chk("addr_latched", zxuno_addr, 8'h0E);
        access(1'b1, DP, 8'h5A, 4, 1'b1, 1);
        chk("wdata_latched", zxuno_wdata, 8'h5A);
        access(1'b0, DP, 8'h00, 4, 1'b1, 1);
        access(1'b1, AP, 8'h90, 4, 1'b1, 0);
        access(1'b0, DP, 8'h00, 5, 1'b1, 0);
        access(1'b0, AP, 8'h00, 4, 1'b1, 0);
        access(1'b0, AP, 8'h00, FILTER, 1'b1, 0);
        access(1'b0, DP, 8'h00, FILTER, 1'b1, 1);

        // Glitch, INTA and foreign address leave state untouched
        access(1'b1, DP, 8'h99, 1, 1'b1, 1);
        chk("glitch_wdata", zxuno_wdata, 8'h5A);
        access(1'b1, AP, 8'h77, 1, 1'b1, 1);
        chk("glitch_addr", zxuno_addr, 8'h90);
        access(1'b1, DP, 8'h66, 4, 1'b0, 1);
        access(1'b0, DP, 8'h00, 4, 1'b0, 1);
        access(1'b1, 16'h00FE, 8'h44, 4, 1'b1, 1);
        chk("foreign_wdata", zxuno_wdata, 8'h5A);
        access(1'b0, 16'h00FE, 8'h00, 4, 1'b1, 1);

        // Reset during a held write strobe: nothing fires until WR is re-asserted
        access(1'b1, AP, 8'h0E, 3, 1'b1, 0);
        cpu_a      = DP;
        cpu_din    = 8'h77;
        cpu_iorq_n = 1'b0;
        cpu_wr_n   = 1'b0;
        rst        = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst        = 1'b0;
        model_addr = 8'h00;
        repeat (6) @(posedge clk);
        #2;
        chk("rst_hold_addr", zxuno_addr, 8'h00);
        chk("rst_hold_wdata", zxuno_wdata, 8'h00);
        idle_bus();
        @(posedge clk);
        #2;
        access(1'b1, DP, 8'h11, 3, 1'b1, 1);

        // Reset while cpu_oe is driving
        cpu_a      = AP;
        cpu_iorq_n = 1'b0;
        cpu_rd_n   = 1'b0;
        push(2, 8'h00, model_addr);
        repeat (FILTER + 1) @(posedge clk);
        #2;
        chk("oe_before_rst", cpu_oe, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #2;
        chk("oe_after_rst", cpu_oe, 1'b0);
        rst = 1'b0;
        idle_bus();
        model_addr = 8'h00;
        @(posedge clk);
        #2;

        // Random back-to-back traffic
        for (int i = 0; i < 100; i++) begin
            r  = $urandom_range(0, 9);
            ra = (r < 5) ? DP : ((r < 9) ? AP : 16'h1234);
            access(1'($urandom_range(0, 1)), ra, 8'($urandom_range(0, 255)),
                   $urandom_range(1, 5), 1'($urandom_range(0, 9) != 0), $urandom_range(0, 2));
        end

        repeat (10) @(posedge clk);
        #2;
        chk("queue_empty", q.size(), 0);
        chk("pulse_count", seen_pulses, exp_pulses);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
